// File: rtl/memory_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : memory_dumper
//  Purpose  : Walks an 8-bit synchronous memory from address 0 to LAST_ADRS
//             and sends each byte out as an 8N1 UART frame (LSB first).
//             Each byte takes one READ and one WAIT clock, so the per-byte
//             period is 2 + 10*CLKS_PER_BIT clocks.
//  Ports    : clock    - system clock, rising edge
//             reset    - asynchronous active-high reset
//             start    - dump request, sampled only while idle
//             mm_adrs  - read address to the synchronous memory
//             mm_q     - memory read data, valid one edge after mm_adrs
//             tx       - registered UART serial output, idles high
//             busy     - high whenever the dumper is not idle
//             done     - one-clock pulse after the final stop bit
//             cur_adrs - address of the byte in flight (display copy)
//  Revision : 1.0 - initial release
// ============================================================================
module memory_dumper #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  LAST_ADRS    = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] mm_adrs,
  input  logic [7:0] mm_q,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [7:0] cur_adrs
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WAIT     = 3'd2,
    ST_TX_START = 3'd3,
    ST_TX_DATA  = 3'd4,
    ST_TX_STOP  = 3'd5
  } state_t;

  localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  logic [7:0]  r_adrs;
  logic [7:0]  r_shift;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic        r_tx;
  logic        r_done;
  logic        w_baud_tc;

  assign w_baud_tc = (r_baud == c_BAUD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_adrs  <= 8'h00;
      r_shift <= 8'h00;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_adrs <= 8'h00;
          r_baud <= 16'd0;
          r_bit  <= 3'd0;
          r_tx   <= 1'b1;
          if (start) begin
            r_state <= ST_READ;
          end
        end

        // Address is presented during READ; the memory registers it on the
        // exit edge, so data is ready to latch at the end of WAIT.
        ST_READ: begin
          r_state <= ST_WAIT;
        end

        // Latch the byte and drop tx on the same edge so the start bit
        // begins immediately.
        ST_WAIT: begin
          r_shift <= mm_q;
          r_baud  <= 16'd0;
          r_bit   <= 3'd0;
          r_tx    <= 1'b0;
          r_state <= ST_TX_START;
        end

        ST_TX_START: begin
          if (w_baud_tc) begin
            r_baud  <= 16'd0;
            r_tx    <= r_shift[0];
            r_state <= ST_TX_DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end

        // tx already carries r_shift[0]; on each bit boundary the next bit
        // (r_shift[1]) is driven and the register shifts right.
        ST_TX_DATA: begin
          if (w_baud_tc) begin
            r_baud <= 16'd0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_TX_STOP;
            end else begin
              r_tx    <= r_shift[1];
              r_shift <= {1'b0, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end

        ST_TX_STOP: begin
          if (w_baud_tc) begin
            r_baud <= 16'd0;
            if (r_adrs == LAST_ADRS) begin
              r_adrs  <= 8'h00;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_adrs  <= r_adrs + 8'd1;
              r_state <= ST_READ;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mm_adrs  = r_adrs;
  assign cur_adrs = r_adrs;
  assign tx       = r_tx;
  assign done     = r_done;
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire
